// File: rtl/shift_burst_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | shift_burst_gen: framed burst of WIDTH shift-clock periods, then idle gap.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module shift_burst_gen #(
  parameter int WIDTH = 150,
  parameter int DIV   = 4,
  parameter int FRAME = 600
) (
  input  logic clk_in,
  input  logic reset,
  input  logic start,
  input  logic mode_cont,
  input  logic abort,
  output logic shift_clk,
  output logic shift_en,
  output logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0] bit_idx,
  output logic burst_active,
  output logic frame_done
);

  localparam int c_BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int c_DW = $clog2(DIV);
  localparam int c_FW = (FRAME > 1) ? $clog2(FRAME) : 1;

  localparam logic [c_DW-1:0] c_DIV_LAST   = c_DW'(DIV - 1);
  localparam logic [c_DW-1:0] c_DIV_HALF   = c_DW'(DIV / 2);
  localparam logic [c_BW-1:0] c_BIT_LAST   = c_BW'(WIDTH - 1);
  localparam logic [c_FW-1:0] c_FRAME_LAST = c_FW'(FRAME - 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_BURST = 2'd1;
  localparam logic [1:0] c_GAP   = 2'd2;

  logic [1:0]      r_state;
  logic [c_DW-1:0] r_div;
  logic [c_FW-1:0] r_frame;
  logic [c_BW-1:0] r_bit;
  logic            r_shift_clk;

  logic [1:0]      w_state_nx;
  logic [c_DW-1:0] w_div_nx;
  logic [c_FW-1:0] w_frame_nx;
  logic [c_BW-1:0] w_bit_nx;
  logic            w_frame_end;
  logic            w_period_end;
  logic            w_burst_last;

  assign w_frame_end  = (r_frame == c_FRAME_LAST);
  assign w_period_end = (r_div == c_DIV_LAST);
  assign w_burst_last = w_period_end && (r_bit == c_BIT_LAST);

  // shift_clk is computed from the next-cycle counters so the register lines up
  // with div_cnt in the same cycle and drops immediately on abort/exit.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_state     <= c_IDLE;
      r_div       <= '0;
      r_frame     <= '0;
      r_bit       <= '0;
      r_shift_clk <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_div       <= w_div_nx;
      r_frame     <= w_frame_nx;
      r_bit       <= w_bit_nx;
      r_shift_clk <= (w_state_nx == c_BURST) && (w_div_nx >= c_DIV_HALF);
    end
  end

  // Counters default to 0 so every exit path (abort, frame end, IDLE) clears them.
  always_comb begin
    w_state_nx = r_state;
    w_div_nx   = '0;
    w_frame_nx = '0;
    w_bit_nx   = '0;
    if (abort) begin
      w_state_nx = c_IDLE;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (start || mode_cont) w_state_nx = c_BURST;
        end
        c_BURST: begin
          if (w_frame_end) begin
            w_state_nx = mode_cont ? c_BURST : c_IDLE;
          end else begin
            w_frame_nx = r_frame + 1'b1;
            if (w_burst_last) begin
              w_state_nx = c_GAP;
            end else begin
              w_div_nx = w_period_end ? '0 : r_div + 1'b1;
              w_bit_nx = w_period_end ? r_bit + 1'b1 : r_bit;
            end
          end
        end
        c_GAP: begin
          if (w_frame_end) w_state_nx = mode_cont ? c_BURST : c_IDLE;
          else             w_frame_nx = r_frame + 1'b1;
        end
        default: w_state_nx = c_IDLE;
      endcase
    end
  end

  always_comb begin
    shift_en     = (r_state == c_BURST) && w_period_end;
    burst_active = (r_state == c_BURST);
    frame_done   = (r_state != c_IDLE) && w_frame_end;
    bit_idx      = r_bit;
    shift_clk    = r_shift_clk;
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_burst_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_shift_burst_gen: directed checks of shift_burst_gen (gap and no-gap).     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_shift_burst_gen;

  logic       clk_in = 1'b0;
  logic       reset  = 1'b1;
  logic       start = 1'b0, mode_cont = 1'b0, abort = 1'b0;
  logic       shift_clk, shift_en, burst_active, frame_done;
  logic [1:0] bit_idx;
  logic       mode_cont2 = 1'b0;
  logic       shift_clk2, shift_en2, burst_active2, frame_done2;
  logic [1:0] bit_idx2;

  int errors = 0;
  int checks = 0;

  shift_burst_gen #(.WIDTH(4), .DIV(4), .FRAME(20)) dut (
    .clk_in(clk_in), .reset(reset), .start(start), .mode_cont(mode_cont),
    .abort(abort), .shift_clk(shift_clk), .shift_en(shift_en),
    .bit_idx(bit_idx), .burst_active(burst_active), .frame_done(frame_done)
  );

  shift_burst_gen #(.WIDTH(4), .DIV(4), .FRAME(16)) dut_ng (
    .clk_in(clk_in), .reset(reset), .start(1'b0), .mode_cont(mode_cont2),
    .abort(1'b0), .shift_clk(shift_clk2), .shift_en(shift_en2),
    .bit_idx(bit_idx2), .burst_active(burst_active2), .frame_done(frame_done2)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_clk"},    32'(shift_clk), 32'd0);
    chk({tag, "_en"},     32'(shift_en), 32'd0);
    chk({tag, "_bit"},    32'(bit_idx), 32'd0);
    chk({tag, "_active"}, 32'(burst_active), 32'd0);
    chk({tag, "_done"},   32'(frame_done), 32'd0);
  endtask

  // Entered on the first BURST cycle; walks one 20-cycle frame with gap.
  task automatic check_frame(input string tag);
    for (int f = 0; f < 20; f++) begin
      chk({tag, "_en"},     32'(shift_en),     32'((f % 4 == 3) && (f < 16)));
      chk({tag, "_clk"},    32'(shift_clk),    32'((f % 4 >= 2) && (f < 16)));
      chk({tag, "_bit"},    32'(bit_idx),      32'((f < 16) ? f / 4 : 0));
      chk({tag, "_active"}, 32'(burst_active), 32'(f < 16));
      chk({tag, "_done"},   32'(frame_done),   32'(f == 19));
      tick();
    end
    chk_idle({tag, "_after"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt_a;
    int cnt_b;
    int cnt_d;

    // Asynchronous reset before any clock edge.
    #1 reset = 1'b0;
    #1 chk_idle("reset_async");
    chk("reset_ng_active", 32'(burst_active2), 32'd0);
    tick(); tick();
    reset = 1'b1;
    tick(); tick();
    chk_idle("idle_no_start");

    // One-shot frame.
    start = 1'b1; tick(); start = 1'b0;
    check_frame("oneshot");
    tick(); tick();
    chk("oneshot_stays_idle", 32'(burst_active), 32'd0);

    // Three continuous frames; mode_cont dropped mid third frame.
    cnt_a = 0;
    mode_cont = 1'b1; tick();
    for (int c = 0; c < 60; c++) begin
      chk("cont_done",   32'(frame_done),   32'(c % 20 == 19));
      chk("cont_active", 32'(burst_active), 32'(c % 20 < 16));
      if (shift_en) cnt_a++;
      if (c == 45) mode_cont = 1'b0;
      tick();
    end
    chk("cont_en_count", 32'(cnt_a), 32'd12);
    chk_idle("cont_end");

    // mode_cont dropped at frame_cnt 5 of frame 2.
    cnt_a = 0; cnt_b = 0; cnt_d = 0;
    mode_cont = 1'b1; tick();
    for (int c = 0; c < 45; c++) begin
      chk("drop_active", 32'(burst_active), 32'((c < 40) && (c % 20 < 16)));
      if (shift_en && c >= 20 && c < 40) cnt_a++;
      if (shift_en && c >= 40) cnt_b++;
      if (frame_done) cnt_d++;
      if (c == 25) mode_cont = 1'b0;
      tick();
    end
    chk("drop_f2_en",    32'(cnt_a), 32'd4);
    chk("drop_f3_en",    32'(cnt_b), 32'd0);
    chk("drop_done_cnt", 32'(cnt_d), 32'd2);

    // abort overrides start and mode_cont from IDLE.
    start = 1'b1; mode_cont = 1'b1; abort = 1'b1; tick();
    start = 1'b0; mode_cont = 1'b0; abort = 1'b0;
    chk_idle("abort_override");

    // abort at frame_cnt 9, restart two cycles later.
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 9; c++) tick();
    chk("abort_pre_bit", 32'(bit_idx), 32'd2);
    chk("abort_pre_active", 32'(burst_active), 32'd1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk_idle("abort_next");
    tick();
    chk_idle("abort_wait");
    start = 1'b1; tick(); start = 1'b0;
    check_frame("restart");

    // Reset asserted between edges at frame_cnt 6.
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    chk("rst_pre_clk", 32'(shift_clk), 32'd1);
    chk("rst_pre_bit", 32'(bit_idx), 32'd1);
    #2 reset = 1'b0;
    #1 chk_idle("rst_mid");
    tick();
    reset = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    chk_idle("rst_release");

    // No-gap configuration, continuous.
    cnt_a = 0;
    mode_cont2 = 1'b1; tick();
    for (int c = 0; c < 48; c++) begin
      chk("ng_en",     32'(shift_en2),     32'(c % 4 == 3));
      chk("ng_clk",    32'(shift_clk2),    32'(c % 4 >= 2));
      chk("ng_bit",    32'(bit_idx2),      32'((c % 16) / 4));
      chk("ng_active", 32'(burst_active2), 32'd1);
      chk("ng_done",   32'(frame_done2),   32'(c % 16 == 15));
      if (shift_en2) cnt_a++;
      if (c == 47) mode_cont2 = 1'b0;
      tick();
    end
    chk("ng_en_count", 32'(cnt_a), 32'd12);
    chk("ng_end_active", 32'(burst_active2), 32'd0);
    chk("ng_end_clk", 32'(shift_clk2), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
